// File: rtl/matrix_tx_scheduler_if.sv
// Command/transmitter bundle for matrix_tx_scheduler.
// The master side is everything outside the scheduler: the two requesters
// plus the transmitter's busy flag. The slave side is the scheduler itself.
interface matrix_tx_scheduler_if;
  // requester 0
  logic       req0;
  logic [1:0] op0;
  logic [2:0] addr0;
  logic [7:0] data0;
  logic       done0;
  // requester 1
  logic       req1;
  logic [1:0] op1;
  logic [2:0] addr1;
  logic [7:0] data1;
  logic       done1;
  // shared completion status
  logic       err;
  // transmitter side
  logic [7:0] d;
  logic       row;
  logic [1:0] col;
  logic [2:0] action;
  logic       tx_busy;
  // status
  logic       sched_busy;

  modport master (
    output req0, op0, addr0, data0,
    output req1, op1, addr1, data1,
    output tx_busy,
    input  done0, done1, err,
    input  d, row, col, action,
    input  sched_busy
  );

  modport slave (
    input  req0, op0, addr0, data0,
    input  req1, op1, addr1, data1,
    input  tx_busy,
    output done0, done1, err,
    output d, row, col, action,
    output sched_busy
  );
endinterface

// File: rtl/matrix_tx_scheduler.sv
// Two-port round-robin command scheduler for a cell-matrix transmitter.
// A granted requester's command is latched once and then executed:
//   WRITE    : one action=1 strobe, no handshake with the transmitter.
//   SEND     : one action=2 strobe, wait for tx_busy to rise then fall.
//   SEND_ALL : eight SEND cycles over cells 0..7 in order.
// A transmitter that never raises tx_busy within four cycles of an issue
// ends the command with err. All transmitter/requester outputs are
// registered; action/d/row/col/done/err follow the FSM state by one cycle.
module matrix_tx_scheduler (
  input  logic                  clk,
  input  logic                  rst,
  matrix_tx_scheduler_if.slave  bus
);

  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_SEND     = 2'd1;
  localparam logic [1:0] OP_SEND_ALL = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  localparam logic [2:0] ACT_IDLE  = 3'd0;
  localparam logic [2:0] ACT_WRITE = 3'd1;
  localparam logic [2:0] ACT_TX    = 3'd2;

  // last WAIT_HI cycle index before a missing tx_busy becomes a timeout
  localparam logic [1:0] TMO_LAST  = 2'd3;
  localparam logic [2:0] LAST_CELL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t     state, state_nxt;

  logic       gid;        // requester currently owning the scheduler
  logic       last_gid;   // requester served most recently
  logic       win;        // arbitration result in IDLE
  logic       any_req;

  logic [1:0] op_l;       // latched command
  logic [7:0] data_l;     // latched write data
  logic [2:0] idx;        // current cell index
  logic [1:0] tcnt;       // cycles spent in WAIT_HI for this cell
  logic       err_l;      // completion status of the current command

  logic [1:0] sel_op;
  logic [2:0] sel_addr;
  logic [7:0] sel_data;

  logic       more_cells;
  logic       tmo;

  assign any_req  = bus.req0 | bus.req1;

  // Port 0 wins a tie unless it was the one served last.
  assign win      = (bus.req0 && bus.req1) ? ~last_gid : bus.req1;

  assign sel_op   = gid ? bus.op1   : bus.op0;
  assign sel_addr = gid ? bus.addr1 : bus.addr0;
  assign sel_data = gid ? bus.data1 : bus.data0;

  assign more_cells = (op_l == OP_SEND_ALL) && (idx != LAST_CELL);
  assign tmo        = !bus.tx_busy && (tcnt == TMO_LAST);

  // Next-state decode for the command sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (sel_op == OP_RSVD) state_nxt = S_DONE;
        else                   state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (op_l == OP_WRITE) state_nxt = S_DONE;
        else                  state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) state_nxt = S_WAIT_LO;
        else if (tmo)    state_nxt = S_DONE;
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (more_cells) state_nxt = S_ISSUE;
          else            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Grant ownership, command latch, cell index and timeout bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gid      <= 1'b0;
      last_gid <= 1'b1;
      op_l     <= OP_WRITE;
      idx      <= 3'd0;
      tcnt     <= 2'd0;
      err_l    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) gid <= win;
        end
        S_GRANT: begin
          op_l  <= sel_op;
          idx   <= (sel_op == OP_SEND_ALL) ? 3'd0 : sel_addr;
          err_l <= (sel_op == OP_RSVD);
        end
        S_ISSUE: begin
          tcnt <= 2'd0;
        end
        S_WAIT_HI: begin
          tcnt <= tcnt + 2'd1;
          if (tmo) err_l <= 1'b1;
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy && more_cells) idx <= idx + 3'd1;
        end
        S_DONE: begin
          last_gid <= gid;
        end
        default: begin
          tcnt <= 2'd0;
        end
      endcase
    end
  end

  // Write data is pure payload and needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_GRANT) data_l <= sel_data;
  end

  // Registered transmitter and requester outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.action     <= ACT_IDLE;
      bus.d          <= 8'd0;
      bus.row        <= 1'b0;
      bus.col        <= 2'd0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.err        <= 1'b0;
      bus.sched_busy <= 1'b0;
    end else begin
      bus.action     <= ACT_IDLE;
      bus.done0      <= (state == S_DONE) && !gid;
      bus.done1      <= (state == S_DONE) &&  gid;
      bus.err        <= (state == S_DONE) && err_l;
      bus.sched_busy <= (state_nxt != S_IDLE);
      // d/row/col are loaded on issue and then held until the next issue
      if (state == S_ISSUE) begin
        bus.action <= (op_l == OP_WRITE) ? ACT_WRITE : ACT_TX;
        bus.d      <= data_l;
        bus.row    <= idx[2];
        bus.col    <= idx[1:0];
      end
    end
  end

endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Directed bench for matrix_tx_scheduler with a small transmitter model.
// Cycle numbers: cycle 0 is the clock period that follows the first rising
// edge at which a new request is visible; all sampling is on falling edges.
module tb_matrix_tx_scheduler;

  logic clk;
  logic rst;

  matrix_tx_scheduler_if bus ();

  matrix_tx_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // monitor state
  int         cyc;
  int         n_act;
  int         n_done;
  int         both_done;
  logic [2:0] act_val  [16];
  logic [2:0] act_addr [16];
  logic [7:0] act_d    [16];
  int         act_cyc  [16];
  logic       act_busy [16];
  logic       act_sb   [16];
  logic       done_port[8];
  int         done_cyc [8];
  logic       done_err [8];

  // transmitter model
  logic tx_en;
  int   pend;
  int   busy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = -1; n_act = 0; n_done = 0; both_done = 0;
  endtask

  task automatic tx_reset();
    bus.tx_busy = 1'b0; pend = 0; busy_cnt = 0;
  endtask

  // One clock: sample DUT outputs on the falling edge, then step the model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.action != 3'd0) begin
      if (n_act < 16) begin
        act_val[n_act]  = bus.action;
        act_addr[n_act] = {bus.row, bus.col};
        act_d[n_act]    = bus.d;
        act_cyc[n_act]  = cyc;
        act_busy[n_act] = bus.tx_busy;
        act_sb[n_act]   = bus.sched_busy;
      end
      n_act++;
    end
    if (bus.done0 && bus.done1) both_done++;
    if (bus.done0 || bus.done1) begin
      if (n_done < 8) begin
        done_port[n_done] = bus.done1;
        done_cyc[n_done]  = cyc;
        done_err[n_done]  = bus.err;
      end
      n_done++;
    end
    // tx_busy rises 2 cycles after an action=2 strobe and stays up 20 cycles
    if (tx_en) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.tx_busy = 1'b1;
          busy_cnt = 20;
        end
      end else if (bus.action == 3'd2) begin
        pend = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int port, input logic [1:0] op, input logic [2:0] addr,
                       input logic [7:0] data, input logic req);
    if (port == 0) begin
      bus.op0 = op; bus.addr0 = addr; bus.data0 = data; bus.req0 = req;
    end else begin
      bus.op1 = op; bus.addr1 = addr; bus.data1 = data; bus.req1 = req;
    end
  endtask

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run_cmd(input int port, input logic [1:0] op, input logic [2:0] addr,
                         input logic [7:0] data, input int budget);
    clear_mon();
    drive(port, op, addr, data, 1'b1);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      tick();
      if (n_done > 0) drive(port, op, addr, data, 1'b0);
    end
    drive(port, op, addr, data, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.d, bus.row, bus.col, bus.action, bus.done0, bus.done1,
                bus.err, bus.sched_busy}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    tx_en = 1'b0;
    tx_reset();
    bus.req0 = 1'b0; bus.op0 = 2'd0; bus.addr0 = 3'd0; bus.data0 = 8'd0;
    bus.req1 = 1'b0; bus.op1 = 2'd0; bus.addr1 = 3'd0; bus.data1 = 8'd0;
    clear_mon();
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // WRITE from port 0, cell 0, 0xAA
    run_cmd(0, 2'd0, 3'd0, 8'hAA, 20);
    idle(3);
    check("wr_done_count", n_done, 1);
    check("wr_done_port",  done_port[0], 0);
    check("wr_done_cyc",   done_cyc[0], 3);
    check("wr_err",        done_err[0], 0);
    check("wr_n_act",      n_act, 1);
    check("wr_action",     act_val[0], 1);
    check("wr_act_cyc",    act_cyc[0], 2);
    check("wr_d",          act_d[0], 8'hAA);
    check("wr_rowcol",     act_addr[0], 0);
    check("wr_sched_busy", act_sb[0], 1);
    check("wr_idle_busy",  bus.sched_busy, 0);

    // SEND from port 1, cell 5 (row 1, col 1), transmitter active
    tx_en = 1'b1;
    run_cmd(1, 2'd1, 3'd5, 8'h00, 60);
    idle(3);
    check("send_done_count", n_done, 1);
    check("send_done_port",  done_port[0], 1);
    check("send_done_cyc",   done_cyc[0], 26);
    check("send_err",        done_err[0], 0);
    check("send_n_act",      n_act, 1);
    check("send_action",     act_val[0], 2);
    check("send_rowcol",     act_addr[0], 3'd5);

    // SEND_ALL from port 0; the addr input must be ignored
    run_cmd(0, 2'd2, 3'd3, 8'h5C, 300);
    idle(3);
    check("all_done_count", n_done, 1);
    check("all_done_port",  done_port[0], 0);
    check("all_err",        done_err[0], 0);
    check("all_n_act",      n_act, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("all_addr%0d", i),   act_addr[i], i);
      check($sformatf("all_action%0d", i), act_val[i], 2);
      check($sformatf("all_busy%0d", i),   act_busy[i], 0);
      check($sformatf("all_cyc%0d", i),    act_cyc[i], 2 + 24 * i);
    end
    check("all_done_cyc", done_cyc[0], 194);

    // Simultaneous requests right after reset, both held
    tx_en = 1'b0;
    tx_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_mon();
    drive(0, 2'd0, 3'd1, 8'h11, 1'b1);
    drive(1, 2'd0, 3'd2, 8'h22, 1'b1);
    for (int i = 0; i < 60 && n_done < 3; i++) tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    idle(3);
    check("arb_done_count", n_done, 3);
    check("arb_first",      done_port[0], 0);
    check("arb_second",     done_port[1], 1);
    check("arb_third",      done_port[2], 0);
    check("arb_both",       both_done, 0);
    check("arb_n_act",      n_act, 3);
    check("arb_d0",         act_d[0], 8'h11);
    check("arb_d1",         act_d[1], 8'h22);
    check("arb_d2",         act_d[2], 8'h11);

    // SEND with tx_busy held low: timeout
    run_cmd(0, 2'd1, 3'd3, 8'h00, 30);
    idle(2);
    check("tmo_done_count", n_done, 1);
    check("tmo_done_cyc",   done_cyc[0], 7);
    check("tmo_err",        done_err[0], 1);
    check("tmo_n_act",      n_act, 1);
    check("tmo_rowcol",     act_addr[0], 3'd3);

    // Reserved op
    run_cmd(1, 2'd3, 3'd0, 8'h00, 20);
    idle(2);
    check("rsvd_done_count", n_done, 1);
    check("rsvd_done_port",  done_port[0], 1);
    check("rsvd_done_cyc",   done_cyc[0], 2);
    check("rsvd_err",        done_err[0], 1);
    check("rsvd_n_act",      n_act, 0);

    // Reset in WAIT_LO of SEND_ALL (third cell), then a fresh WRITE
    tx_en = 1'b1;
    clear_mon();
    drive(0, 2'd2, 3'd0, 8'h5C, 1'b1);
    for (int i = 0; i < 200 && !(n_act >= 3 && bus.tx_busy); i++) tick();
    tick();
    check("mid_n_act",  n_act, 3);
    check("mid_col",    bus.col, 2);
    check("mid_busy",   bus.sched_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset_outputs");
    bus.req0 = 1'b0;
    tx_reset();
    idle(2);
    rst = 1'b0;
    clear_mon();
    idle(6);
    check("mid_no_done", n_done, 0);
    check("mid_no_act",  n_act, 0);
    run_cmd(1, 2'd0, 3'd6, 8'h3C, 20);
    idle(2);
    check("post_done_count", n_done, 1);
    check("post_done_port",  done_port[0], 1);
    check("post_done_cyc",   done_cyc[0], 3);
    check("post_err",        done_err[0], 0);
    check("post_d",          act_d[0], 8'h3C);
    check("post_rowcol",     act_addr[0], 3'd6);
    check("post_action",     act_val[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_tx_scheduler.md
MATRIX_TX_SCHEDULER -- requirements
Module: matrix_tx_scheduler

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req0, req1  input  1 each  requester n command request, level, held until its done pulse.
REQ-004 op0, op1  input  2 each  command: 0=WRITE cell, 1=SEND one cell, 2=SEND_ALL 8 cells, 3=reserved.
REQ-005 addr0, addr1  input  3 each  cell address {row, col[1:0]}, cell index 0..7.
REQ-006 data0, data1  input  8 each  write data; used only for WRITE.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to requester n.
REQ-008 err  output  1  valid with any done pulse: 1 = reserved op or busy timeout.
REQ-009 d  output  8  data to the transmitter d0..d7 (d[0]=d0).
REQ-010 row  output  1; col  output  2  cell select to the transmitter.
REQ-011 action  output  3  transmitter command: 0 idle, 1 write, 2 transmit one cell; bit0=action0.
REQ-012 tx_busy  input  1  transmitter busy.
REQ-013 sched_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, GRANT, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-015 IDLE: on any req, arbitrate; GRANT next cycle latches winner's op/addr/data, sets grant id.
REQ-016 Arbitration round-robin: winner = requester other than last-granted if both request; last-granted resets to 1 (port 0 wins first tie).
REQ-017 Latched fields are used for the whole command; requester inputs are ignored after GRANT.
REQ-018 op=3 in GRANT: go straight to DONE with err=1; action never leaves 0.
REQ-019 ISSUE: drive d, row, col from latched fields, action nonzero for exactly one cycle (1 for WRITE, 2 for SEND/SEND_ALL); d/row/col held stable from ISSUE until leaving WAIT_LO.
REQ-020 WRITE: ISSUE -> DONE; no tx_busy wait.
REQ-021 SEND: ISSUE -> WAIT_HI; WAIT_HI waits for tx_busy=1, then WAIT_LO waits for tx_busy=0, then DONE.
REQ-022 Timeout: tx_busy not seen high within 4 cycles after the ISSUE cycle -> DONE with err=1, remaining cells of SEND_ALL abandoned.
REQ-023 WAIT_LO has no timeout.
REQ-024 SEND_ALL: ignores addr; cell index starts at 0; after each WAIT_LO exit, index=7 -> DONE, else index+1 -> ISSUE; 8 action=2 pulses total, addresses 0..7 in order.
REQ-025 DONE: one-cycle done pulse to granted requester only, err valid same cycle, then IDLE; last-granted updated.
REQ-026 A req still high in the cycle after done is a new request.
REQ-027 Latency WRITE: req at edge N (IDLE) -> action=1 during cycle N+2 -> done during cycle N+3.
REQ-028 tx_busy already high at ISSUE counts as seen high in WAIT_HI.
REQ-029 Outputs d, row, col, action, done, err, sched_busy are registered.

Reset
REQ-030 rst asserted, including mid-command: state=IDLE, action=0, d=0, row=0, col=0, done0=done1=0, err=0, sched_busy=0, cell index=0, last-granted=1, immediately and without a clock edge.
REQ-031 A command interrupted by reset is dropped; no done is issued for it.

Verification
REQ-032 req0 WRITE addr=0 data=0xAA -> action=1 for one cycle with d=0xAA, row=0, col=0; done0 3 cycles after req; err=0.
REQ-033 req1 SEND addr=5, model raises tx_busy 2 cycles after action for 20 cycles -> row=1, col=1, single action=2 pulse; done1 after tx_busy falls; err=0.
REQ-034 req0 SEND_ALL -> 8 action=2 pulses, addresses 0..7 in order; each pulse only after tx_busy falls from the previous one; one done0 at end.
REQ-035 req0 and req1 raised same cycle after reset, both held -> port 0 served first, then port 1, then port 0 again; never two grants at once.
REQ-036 SEND with tx_busy tied 0 -> done with err=1 5 cycles after ISSUE; op=3 -> done with err=1, action stays 0.
REQ-037 rst pulsed during WAIT_LO of SEND_ALL -> all outputs 0 asynchronously, no done; new WRITE after reset completes normally.
